// File: rtl/crossing_scheduler_pkg.sv
// Shared encodings for the crossing scheduler and the light-controller bench.
// Holds the FSM states, the grant codes and the round-robin pick.
package crossing_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CROSS = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic GRANT_PED = 1'b0;
  localparam logic GRANT_CYC = 1'b1;

  // On a tie the requester that was not served last wins.
  function automatic logic rr_pick(input logic ped, input logic cyc, input logic last);
    if (ped && cyc) return (last == GRANT_CYC) ? GRANT_PED : GRANT_CYC;
    else if (cyc)   return GRANT_CYC;
    else            return GRANT_PED;
  endfunction

endpackage

// File: rtl/crossing_scheduler_tick.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
// The counter runs 0..TICK_DIV-1 and tick marks the terminal count.
module tick_prescaler #(
  parameter int TICK_DIV = 8
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)              count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/crossing_scheduler.sv
// Schedules pedestrian/cyclist crossings: latches button presses, arbitrates
// round-robin, pulses start and holds busy through the crossing and gap.
//
// state | meaning
// IDLE  | no crossing in progress, waiting for a pending request
// ISSUE | one cycle: start pulse, grant chosen, granted request cleared
// CROSS | crossing held for CROSS_TICKS ticks
// GAP   | vehicle-green gap for MIN_GAP_TICKS ticks before the next crossing
module crossing_scheduler
  import crossing_scheduler_pkg::*;
#(
  parameter int TICK_DIV      = 8,
  parameter int CROSS_TICKS   = 11,
  parameter int MIN_GAP_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ped_button,
  input  logic cyc_button,
  output logic start,
  output logic grant,
  output logic busy,
  output logic ped_wait,
  output logic cyc_wait
);

  localparam int MAX_TICKS = (CROSS_TICKS > MIN_GAP_TICKS) ? CROSS_TICKS : MIN_GAP_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] CROSS_LOAD = CNT_W'(CROSS_TICKS);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(MIN_GAP_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             ped_q, cyc_q;
  logic             ped_pend, cyc_pend;
  logic             last_grant;
  logic             ped_edge, cyc_edge;
  logic             pick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign ped_edge = ped_button & ~ped_q;
  assign cyc_edge = cyc_button & ~cyc_q;
  assign pick     = rr_pick(ped_pend, cyc_pend, last_grant);
  assign ped_wait = ped_pend;
  assign cyc_wait = cyc_pend;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      ped_q      <= 1'b0;
      cyc_q      <= 1'b0;
      ped_pend   <= 1'b0;
      cyc_pend   <= 1'b0;
      last_grant <= GRANT_CYC;
      start      <= 1'b0;
      busy       <= 1'b0;
      grant      <= GRANT_PED;
    end else begin
      ped_q    <= ped_button;
      cyc_q    <= cyc_button;
      start    <= 1'b0;
      ped_pend <= ped_pend | ped_edge;
      cyc_pend <= cyc_pend | cyc_edge;

      case (state)
        IDLE: begin
          if (ped_pend || cyc_pend) begin
            state      <= ISSUE;
            start      <= 1'b1;
            busy       <= 1'b1;
            grant      <= pick;
            last_grant <= pick;
          end
        end
        ISSUE: begin
          count <= CROSS_LOAD;
          state <= CROSS;
          // A fresh press from the served requester is merged into this crossing.
          if (grant == GRANT_PED) ped_pend <= 1'b0;
          else                    cyc_pend <= 1'b0;
        end
        CROSS: begin
          if (tick) begin
            if (count == CNT_ONE) begin
              count <= GAP_LOAD;
              state <= GAP;
            end else if (count != '0) begin
              count <= count - 1'b1;
            end
          end
        end
        GAP: begin
          if (tick && count != '0) begin
            count <= count - 1'b1;
            if (count == CNT_ONE) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
